// File: rtl/monitoreo_multicanal.sv
// monitoreo_multicanal: per-channel temperature monitor with heater/fan control
// and persistence-qualified alerts. Samples arrive one per cycle, tagged with a
// channel index; only the addressed channel's FSM advances.
// Optional feature: define MONITOREO_WATCHDOG_EN to add a per-channel idle
// watchdog that forces a channel into ALERTA when it stops receiving samples.
module monitoreo_multicanal #(
  parameter int N_CANALES = 4,
  parameter int W         = 10,
  parameter int T_BAJO    = 180,
  parameter int T_ALTO    = 260,
  parameter int HIST      = 10,
  parameter int N_PERSIST = 5,
  parameter int WD_CICLOS = 1000
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   temp_valid,
  input  logic [((N_CANALES > 1) ? $clog2(N_CANALES) : 1)-1:0]   temp_canal,
  input  logic signed [W-1:0]                                    temp_entrada,
  output logic [2*N_CANALES-1:0]                                 estado_actual,
  output logic [N_CANALES-1:0]                                   calefactor,
  output logic [N_CANALES-1:0]                                   ventilador,
  output logic [N_CANALES-1:0]                                   alerta_canal,
  output logic                                                   alerta,
  output logic                                                   err_canal
);

  localparam int CW    = (N_CANALES > 1) ? $clog2(N_CANALES) : 1;
  localparam int CNT_W = (N_PERSIST > 0) ? $clog2(N_PERSIST + 1) : 1;

  // Thresholds resized to the sample width so every compare is signed W-bit.
  localparam logic signed [W-1:0] LIM_BAJO = W'(T_BAJO);
  localparam logic signed [W-1:0] LIM_ALTO = W'(T_ALTO);
  localparam logic signed [W-1:0] REC_BAJO = W'(T_BAJO + HIST);
  localparam logic signed [W-1:0] REC_ALTO = W'(T_ALTO - HIST);

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(N_PERSIST);
  localparam logic [CNT_W-1:0] CNT_UMBRAL = CNT_W'(N_PERSIST - 1);
  localparam logic [CW:0]      N_LIM     = (CW + 1)'(N_CANALES);

  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    FRIO   = 2'b01,
    CALOR  = 2'b10,
    ALERTA = 2'b11
  } estado_t;

  // Remembers why a channel is in ALERTA so the right actuator stays on.
  typedef enum logic [1:0] {
    CAUSA_NINGUNA = 2'b00,
    CAUSA_FRIO    = 2'b01,
    CAUSA_CALOR   = 2'b10
  } causa_t;

  estado_t          st     [N_CANALES];
  estado_t          st_n   [N_CANALES];
  logic [CNT_W-1:0] cnt    [N_CANALES];
  logic [CNT_W-1:0] cnt_n  [N_CANALES];
  causa_t           causa  [N_CANALES];
  causa_t           causa_n[N_CANALES];

  estado_t clase;
  logic    en_rango;
  logic    acepta;
  logic    err_n;

`ifdef MONITOREO_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_CICLOS + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WD_CICLOS);

  logic [WD_W-1:0] wd   [N_CANALES];
  logic [WD_W-1:0] wd_n [N_CANALES];
`endif

  // Classify the incoming sample, decide acceptance and compute every channel's next state.
  always_comb begin
    clase = NORMAL;
    if (temp_entrada < LIM_BAJO)
      clase = FRIO;
    else if (temp_entrada > LIM_ALTO)
      clase = CALOR;

    en_rango = (temp_entrada >= REC_BAJO) && (temp_entrada <= REC_ALTO);
    acepta   = temp_valid && ({1'b0, temp_canal} < N_LIM);
    err_n    = temp_valid && !({1'b0, temp_canal} < N_LIM);

    for (int i = 0; i < N_CANALES; i++) begin
      st_n[i]    = st[i];
      cnt_n[i]   = cnt[i];
      causa_n[i] = causa[i];

      if (acepta && (temp_canal == CW'(i))) begin
        case (st[i])
          NORMAL: begin
            if (clase != NORMAL) begin
              st_n[i]  = clase;
              cnt_n[i] = CNT_W'(1);
            end else begin
              cnt_n[i] = '0;
            end
          end
          FRIO, CALOR: begin
            if (clase == NORMAL) begin
              st_n[i]  = NORMAL;
              cnt_n[i] = '0;
            end else if (clase == st[i]) begin
              if (cnt[i] >= CNT_UMBRAL) begin
                st_n[i]    = ALERTA;
                cnt_n[i]   = CNT_MAX;
                causa_n[i] = (st[i] == FRIO) ? CAUSA_FRIO : CAUSA_CALOR;
              end else begin
                cnt_n[i] = cnt[i] + CNT_W'(1);
              end
            end else begin
              st_n[i]  = clase;
              cnt_n[i] = CNT_W'(1);
            end
          end
          default: begin
            if (en_rango) begin
              st_n[i]    = NORMAL;
              cnt_n[i]   = '0;
              causa_n[i] = CAUSA_NINGUNA;
            end
          end
        endcase
      end

`ifdef MONITOREO_WATCHDOG_EN
      // A sample in the same cycle wins over a timeout and restarts the count.
      if (acepta && (temp_canal == CW'(i))) begin
        wd_n[i] = '0;
      end else begin
        wd_n[i] = (wd[i] == WD_MAX) ? wd[i] : wd[i] + WD_W'(1);
        if ((wd_n[i] == WD_MAX) && (wd[i] != WD_MAX)) begin
          st_n[i]    = ALERTA;
          cnt_n[i]   = '0;
          causa_n[i] = CAUSA_NINGUNA;
        end
      end
`endif
    end
  end

  // State, persistence counters, causes and the error pulse update on each rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CANALES; i++) begin
        st[i]    <= NORMAL;
        cnt[i]   <= '0;
        causa[i] <= CAUSA_NINGUNA;
`ifdef MONITOREO_WATCHDOG_EN
        wd[i]    <= '0;
`endif
      end
      err_canal <= 1'b0;
    end else begin
      for (int i = 0; i < N_CANALES; i++) begin
        st[i]    <= st_n[i];
        cnt[i]   <= cnt_n[i];
        causa[i] <= causa_n[i];
`ifdef MONITOREO_WATCHDOG_EN
        wd[i]    <= wd_n[i];
`endif
      end
      err_canal <= err_n;
    end
  end

  // Actuator and alert outputs are decoded purely from the state flops.
  always_comb begin
    estado_actual = '0;
    calefactor    = '0;
    ventilador    = '0;
    alerta_canal  = '0;
    for (int i = 0; i < N_CANALES; i++) begin
      estado_actual[2*i +: 2] = st[i];
      alerta_canal[i] = (st[i] == ALERTA);
      calefactor[i]   = (st[i] == FRIO)  || ((st[i] == ALERTA) && (causa[i] == CAUSA_FRIO));
      ventilador[i]   = (st[i] == CALOR) || ((st[i] == ALERTA) && (causa[i] == CAUSA_CALOR));
    end
    alerta = |alerta_canal;
  end

endmodule

// File: tb/tb_monitoreo_multicanal.sv
// tb_monitoreo_multicanal: drives a 4-channel and a 3-channel monitor from the
// same inputs; table vectors, hand-written corner sequences and a randomized
// run compared against a behavioural model. Define MONITOREO_WATCHDOG_EN to
// also exercise the idle watchdog.
module tb_monitoreo_multicanal;

  localparam int T_BAJO = 180;
  localparam int T_ALTO = 260;
  localparam int HIST   = 10;
  localparam int NP     = 5;

  logic clk = 1'b0;
  logic rst;
  logic temp_valid;
  logic [1:0] temp_canal;
  logic signed [9:0] temp_entrada;

  logic [7:0] e4;
  logic [3:0] cal4, ven4, alc4;
  logic       al4, err4;
  logic [5:0] e3;
  logic [2:0] cal3, ven3, alc3;
  logic       al3, err3;

  int nChecks = 0;
  int nPass   = 0;

  int  mst   [2][4];
  int  mcnt  [2][4];
  int  mcause[2][4];
  bit  merr  [2];

  typedef struct {
    logic       v;
    int         c;
    int         t;
    logic [7:0] est;
    logic [3:0] cal;
    logic [3:0] ven;
    logic [3:0] alc;
    logic       al;
  } vec_t;

  vec_t tbl[14];

  monitoreo_multicanal #(.N_CANALES(4)) dut4 (
    .clk(clk), .rst(rst), .temp_valid(temp_valid), .temp_canal(temp_canal),
    .temp_entrada(temp_entrada), .estado_actual(e4), .calefactor(cal4),
    .ventilador(ven4), .alerta_canal(alc4), .alerta(al4), .err_canal(err4)
  );

  monitoreo_multicanal #(.N_CANALES(3)) dut3 (
    .clk(clk), .rst(rst), .temp_valid(temp_valid), .temp_canal(temp_canal),
    .temp_entrada(temp_entrada), .estado_actual(e3), .calefactor(cal3),
    .ventilador(ven3), .alerta_canal(alc3), .alerta(al3), .err_canal(err3)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic void modelReset();
    for (int d = 0; d < 2; d++) begin
      merr[d] = 1'b0;
      for (int c = 0; c < 4; c++) begin
        mst[d][c] = 0; mcnt[d][c] = 0; mcause[d][c] = 0;
      end
    end
  endfunction

  // Behavioural rule set: 0 normal, 1 cold, 2 hot, 3 alert.
  function automatic void modelStep(int d, bit v, int c, int t);
    int nch = (d == 0) ? 4 : 3;
    int cls;
    merr[d] = v && (c >= nch);
    if (!(v && c < nch)) return;
    cls = (t < T_BAJO) ? 1 : ((t > T_ALTO) ? 2 : 0);
    if (mst[d][c] == 3) begin
      if (t >= T_BAJO + HIST && t <= T_ALTO - HIST) begin
        mst[d][c] = 0; mcnt[d][c] = 0; mcause[d][c] = 0;
      end
    end else if (cls == 0) begin
      mst[d][c] = 0; mcnt[d][c] = 0;
    end else if (mst[d][c] == cls) begin
      mcnt[d][c] = mcnt[d][c] + 1;
      if (mcnt[d][c] >= NP) begin
        mst[d][c] = 3; mcause[d][c] = cls; mcnt[d][c] = NP;
      end
    end else begin
      mst[d][c] = cls; mcnt[d][c] = 1;
    end
  endfunction

  function automatic logic [31:0] expEstado(int d);
    int nch = (d == 0) ? 4 : 3;
    logic [31:0] r = 0;
    for (int c = 0; c < nch; c++) r = r | (32'(mst[d][c]) << (2 * c));
    return r;
  endfunction

  function automatic logic [31:0] expFlags(int d);
    int nch = (d == 0) ? 4 : 3;
    logic [31:0] cal = 0, ven = 0, alc = 0;
    for (int c = 0; c < nch; c++) begin
      if (mst[d][c] == 1 || (mst[d][c] == 3 && mcause[d][c] == 1)) cal[c] = 1'b1;
      if (mst[d][c] == 2 || (mst[d][c] == 3 && mcause[d][c] == 2)) ven[c] = 1'b1;
      if (mst[d][c] == 3) alc[c] = 1'b1;
    end
    return (cal << (2 * nch + 2)) | (ven << (nch + 2)) | (alc << 2)
           | (32'(alc != 0) << 1) | 32'(merr[d]);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic v, input int c, input int t);
    temp_valid   = v;
    temp_canal   = c[1:0];
    temp_entrada = t[9:0];
    modelStep(0, v, c, t);
    modelStep(1, v, c, t);
    @(posedge clk);
    #1;
    temp_valid = 1'b0;
  endtask

  task automatic doReset(input logic v);
    rst          = 1'b1;
    temp_valid   = v;
    temp_canal   = 2'd0;
    temp_entrada = 10'sd100;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    temp_valid = 1'b0;
    modelReset();
  endtask

  initial begin
    int tend[4];
    int coldV[4];
    int hotV[4];
    int midV[6];
    int r, c, t;
    logic v;

    coldV = '{100, 179, -300, 150};
    hotV  = '{261, 300, 450, 270};
    midV  = '{180, 190, 220, 250, 260, 185};

    tbl[0]  = '{1'b1, 0, 100, 8'h01, 4'h1, 4'h0, 4'h0, 1'b0};
    tbl[1]  = '{1'b1, 0, 100, 8'h01, 4'h1, 4'h0, 4'h0, 1'b0};
    tbl[2]  = '{1'b1, 0, 100, 8'h01, 4'h1, 4'h0, 4'h0, 1'b0};
    tbl[3]  = '{1'b1, 0, 100, 8'h01, 4'h1, 4'h0, 4'h0, 1'b0};
    tbl[4]  = '{1'b1, 0, 100, 8'h03, 4'h1, 4'h0, 4'h1, 1'b1};
    tbl[5]  = '{1'b1, 0, 185, 8'h03, 4'h1, 4'h0, 4'h1, 1'b1};
    tbl[6]  = '{1'b1, 0, 220, 8'h00, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[7]  = '{1'b1, 1, 180, 8'h00, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[8]  = '{1'b1, 1, 260, 8'h00, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[9]  = '{1'b1, 1, 179, 8'h04, 4'h2, 4'h0, 4'h0, 1'b0};
    tbl[10] = '{1'b1, 1, 261, 8'h08, 4'h0, 4'h2, 4'h0, 1'b0};
    tbl[11] = '{1'b0, 1, 100, 8'h08, 4'h0, 4'h2, 4'h0, 1'b0};
    tbl[12] = '{1'b1, 1, 220, 8'h00, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[13] = '{1'b1, 1, 250, 8'h00, 4'h0, 4'h0, 4'h0, 1'b0};

    rst = 1'b0; temp_valid = 1'b0; temp_canal = 2'd0; temp_entrada = '0;
    modelReset();
    @(negedge clk);

    // Reset state
    doReset(1'b0);
    checkOutput("reset_estado", 32'(e4), 32'h0);
    checkOutput("reset_flags", 32'({cal4, ven4, alc4, al4, err4}), 32'h0);

    // Table vectors: cold persistence, hysteresis exit, classification boundaries
    for (int i = 0; i < 14; i++) begin
      applyStimulus(tbl[i].v, tbl[i].c, tbl[i].t);
      checkOutput($sformatf("tbl%0d_estado", i), 32'(e4), 32'(tbl[i].est));
      checkOutput($sformatf("tbl%0d_cal", i), 32'(cal4), 32'(tbl[i].cal));
      checkOutput($sformatf("tbl%0d_ven", i), 32'(ven4), 32'(tbl[i].ven));
      checkOutput($sformatf("tbl%0d_alc", i), 32'({alc4, al4, err4}), 32'({tbl[i].alc, tbl[i].al, 1'b0}));
    end

    // Hot persistence on channel 2 broken by one cold sample
    doReset(1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2, 300);
    applyStimulus(1'b1, 2, 100);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2, 300);
    checkOutput("hot4_estado", 32'(e4), 32'h20);
    checkOutput("hot4_alerta", 32'(al4), 32'h0);
    applyStimulus(1'b1, 2, 300);
    checkOutput("hot5_estado", 32'(e4), 32'h30);
    checkOutput("hot5_act", 32'({cal4, ven4, alc4, al4}), 32'({4'h0, 4'h4, 4'h4, 1'b1}));

    // Invalid channel index on the 3-channel instance, then reset mid-persistence
    doReset(1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 0, 100);
    checkOutput("n3_cold3", 32'(e3), 32'h01);
    applyStimulus(1'b1, 3, 100);
    checkOutput("n3_err_pulse", 32'(err3), 32'h1);
    checkOutput("n3_err_estado", 32'(e3), 32'h01);
    checkOutput("n4_no_err", 32'(err4), 32'h0);
    applyStimulus(1'b0, 0, 0);
    checkOutput("n3_err_clear", 32'(err3), 32'h0);
    doReset(1'b1);
    checkOutput("n3_rst_outs", 32'({e3, cal3, ven3, alc3, al3, err3}), 32'h0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 0, 100);
    checkOutput("n3_fresh4", 32'({e3, al3}), 32'({6'h01, 1'b0}));
    applyStimulus(1'b1, 0, 100);
    checkOutput("n3_fresh5", 32'({e3, cal3, al3}), 32'({6'h03, 3'h1, 1'b1}));

    // Randomized run against the behavioural model
    doReset(1'b0);
    for (int k = 0; k < 4; k++) tend[k] = $urandom_range(0, 2);
    for (int n = 0; n < 600; n++) begin
      if (n % 40 == 0) for (int k = 0; k < 4; k++) tend[k] = $urandom_range(0, 2);
      if ($urandom_range(0, 149) == 0) begin
        doReset($urandom_range(0, 1) == 1);
      end else begin
        v = ($urandom_range(0, 9) < 8);
        c = $urandom_range(0, 3);
        r = $urandom_range(0, 99);
        if (r < 85) begin
          if (tend[c] == 0)      t = coldV[$urandom_range(0, 3)];
          else if (tend[c] == 1) t = hotV[$urandom_range(0, 3)];
          else                   t = midV[$urandom_range(0, 5)];
        end else begin
          t = int'($urandom_range(0, 1023)) - 512;
        end
        applyStimulus(v, c, t);
      end
      checkOutput($sformatf("rnd%0d_e4", n), 32'(e4), expEstado(0));
      checkOutput($sformatf("rnd%0d_f4", n), 32'({cal4, ven4, alc4, al4, err4}), expFlags(0));
      checkOutput($sformatf("rnd%0d_e3", n), 32'(e3), expEstado(1));
      checkOutput($sformatf("rnd%0d_f3", n), 32'({cal3, ven3, alc3, al3, err3}), expFlags(1));
    end

`ifdef MONITOREO_WATCHDOG_EN
    // Idle watchdog on channel 1: fires on the 1000th idle cycle
    doReset(1'b0);
    for (int i = 0; i < 999; i++) applyStimulus(1'b0, 0, 0);
    checkOutput("wd_before", 32'(alc4[1]), 32'h0);
    applyStimulus(1'b0, 0, 0);
    checkOutput("wd_fire", 32'({alc4[1], cal4[1], ven4[1], e4[3:2]}), 32'({1'b1, 1'b0, 1'b0, 2'b11}));
    applyStimulus(1'b1, 1, 220);
    checkOutput("wd_exit", 32'({alc4[1], e4[3:2]}), 32'h0);
`endif

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/monitoreo_multicanal.md
MONITOREO_MULTICANAL -- requirements
Module: monitoreo_multicanal

Interface
REQ-001 Parameter N_CANALES, default 4: number of independent monitored channels (1..16).
REQ-002 Parameter W, default 10: temperature width, signed two's complement, units of 0.1 C.
REQ-003 Parameters T_BAJO 180, T_ALTO 260, HIST 10, N_PERSIST 5, WD_CICLOS 1000: cold threshold, hot threshold, recovery hysteresis, persistence count and watchdog period.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 temp_valid  in  1  sample strobe; one sample per cycle, no backpressure.
REQ-007 temp_canal  in  $clog2(N_CANALES) (min 1)  channel index of the sample.
REQ-008 temp_entrada  in  W  signed sample value.
REQ-009 estado_actual  out  2*N_CANALES  per-channel state, channel i at bits [2i+1:2i].
REQ-010 calefactor, ventilador, alerta_canal  out  N_CANALES each  per-channel heater, fan and alert.
REQ-011 alerta  out  1  OR of alerta_canal.
REQ-012 err_canal  out  1  one-cycle pulse on an invalid channel index.

Function
REQ-013 Classification, signed compare: FRIO if temp < T_BAJO, CALOR if temp > T_ALTO, else NORMAL; boundary values T_BAJO and T_ALTO classify NORMAL.
REQ-014 Per-channel FSM states: NORMAL=00, FRIO=01, CALOR=10, ALERTA=11.
REQ-015 Only an accepted sample (temp_valid=1, temp_canal<N_CANALES) advances the FSM of its addressed channel; all other channels hold.
REQ-016 Latency: all outputs are registered and reflect an accepted sample on the cycle after acceptance.
REQ-017 NORMAL: a FRIO sample goes to FRIO with cnt=1; a CALOR sample goes to CALOR with cnt=1; a NORMAL sample stays in NORMAL with cnt=0.
REQ-018 FRIO: a FRIO sample increments cnt, and when cnt reaches N_PERSIST the channel goes to ALERTA with cause=FRIO; a NORMAL sample goes to NORMAL with cnt=0; a CALOR sample goes to CALOR with cnt=1.
REQ-019 CALOR: symmetric to FRIO, with cause=CALOR on entry to ALERTA.
REQ-020 ALERTA: exits to NORMAL with cnt=0 only on a sample in [T_BAJO+HIST, T_ALTO-HIST] inclusive; any other sample holds ALERTA and keeps the existing cause.
REQ-021 Persistence counter width is $clog2(N_PERSIST+1), and the counter saturates at N_PERSIST.
REQ-022 calefactor[i]=1 in FRIO, or in ALERTA with cause=FRIO; ventilador[i]=1 in CALOR, or in ALERTA with cause=CALOR; the two are never both 1.
REQ-023 alerta_canal[i]=1 exactly when channel i is in ALERTA.
REQ-024 When temp_valid=1 and temp_canal>=N_CANALES, the sample is dropped, err_canal pulses for one cycle, and no state changes.

Reset
REQ-025 While rst=1 at a clock edge, all channels go to NORMAL with cnt=0 and cause cleared; all outputs read 0 on the next cycle.
REQ-026 Reset takes priority over a simultaneous temp_valid, and that sample is discarded.
REQ-027 Reset mid-persistence or mid-ALERTA discards all history; after reset release, N_PERSIST fresh samples are needed to alert.

Configuration
REQ-028 Macro MONITOREO_WATCHDOG_EN: when defined, each channel has a counter of cycles since its last accepted sample.
REQ-029 The watchdog counter clears on any accepted sample for its channel and on reset.
REQ-030 When the watchdog counter reaches WD_CICLOS, the channel enters ALERTA with cause=NONE: alerta_canal=1, calefactor=0, ventilador=0.
REQ-031 A watchdog ALERTA exits by the same hysteresis rule as REQ-020.
REQ-032 If a timeout and an accepted sample occur in the same cycle, the sample wins and the watchdog counter clears.
REQ-033 When MONITOREO_WATCHDOG_EN is undefined, no watchdog logic exists and cause=NONE is unreachable.

Verification
REQ-034 Scenario: channel 0 receives 4x temp=100 -> estado=01, calefactor[0]=1, alerta=0; a 5th temp=100 -> estado=11 and alerta=1 one cycle later.
REQ-035 Scenario: from a channel-0 cold ALERTA, temp=185 holds ALERTA; then temp=220 -> estado=00, alerta=0, calefactor[0]=0.
REQ-036 Scenario: channel 2 receives 3x temp=300, then temp=100, then 4x temp=300 -> no alert; a 5th consecutive temp=300 -> ALERTA with ventilador[2]=1; channels 0, 1 and 3 remain 00.
REQ-037 Scenario: boundary values 180 and 260 -> NORMAL; 179 -> FRIO; 261 -> CALOR.
REQ-038 Scenario: with N_CANALES=3, temp_canal=3 -> err_canal pulses for one cycle and all estado bits are unchanged; rst asserted after 3 cold samples -> all outputs 0, then 5 fresh cold samples are needed to alert.
REQ-039 Scenario (with MONITOREO_WATCHDOG_EN): channel 1 idle for 1000 cycles -> alerta_canal[1]=1 with calefactor and ventilador both 0; temp=220 -> NORMAL.
